// File: rtl/local_mem_bank_if.sv
// OBI request/response interfaces between the local-memory crossbar
// and each local_mem_bank: request channel with gnt, response channel.
interface obi_req_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;

    modport master (output req, addr, we, be, wdata, input gnt);
    modport slave  (input req, addr, we, be, wdata, output gnt);
endinterface

interface obi_rsp_if;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output rvalid, rdata);
    modport slave  (input rvalid, rdata);
endinterface

// File: rtl/local_mem_bank.sv
// local_mem_bank: single-port SRAM bank behind the interleaved crossbar.
// Word reads, byte-enabled writes, in-order responses after LATENCY cycles.
// Ports: clk_i, rst_ni (async, active-low), mem_req (obi_req_if.slave:
//   req/addr/we/be/wdata in, gnt out), mem_rsp (obi_rsp_if.master:
//   rvalid/rdata out).
// Option: define LOCAL_MEM_BANK_ZERO_INIT_EN to zero the array after every
//   reset (gnt held low for DEPTH cycles while it clears).
module local_mem_bank #(
    parameter int SIZE_BYTE = 4096,
    parameter int NUM_BANKS = 4,
    parameter int LATENCY   = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    obi_req_if.slave  mem_req,
    obi_rsp_if.master mem_rsp
);
    localparam int DEPTH = SIZE_BYTE / 4;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SHIFT = 2 + $clog2(NUM_BANKS);

    if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
        $error("local_mem_bank: LATENCY must be in 1..3");
    end

    logic [31:0]   r_mem [DEPTH];
    logic          w_gnt;
    logic          w_acc;
    logic          w_wr;
    logic          w_init;
    logic [AW-1:0] w_init_idx;
    logic [AW-1:0] w_idx;

    // Bank-select and byte-offset bits are dropped; upper bits wrap.
    assign w_idx = AW'((mem_req.addr >> SHIFT) % DEPTH);
    assign w_acc = mem_req.req & w_gnt;
    assign w_wr  = w_acc & mem_req.we;

`ifdef LOCAL_MEM_BANK_ZERO_INIT_EN
    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_init_idx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_INIT;
            r_init_idx <= '0;
        end else if (r_state == ST_INIT) begin
            if (r_init_idx == AW'(DEPTH - 1)) begin
                r_state <= ST_READY;
            end
            r_init_idx <= r_init_idx + 1'b1;
        end
    end

    assign w_gnt      = (r_state == ST_READY);
    assign w_init     = (r_state == ST_INIT);
    assign w_init_idx = r_init_idx;
`else
    assign w_gnt      = 1'b1;
    assign w_init     = 1'b0;
    assign w_init_idx = '0;
`endif

    assign mem_req.gnt = w_gnt;

    // Array has no reset; clearing (when enabled) is done by the INIT sweep.
    always_ff @(posedge clk_i) begin
        if (w_init) begin
            r_mem[w_init_idx] <= '0;
        end else if (w_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_req.be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= mem_req.wdata[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline. Read data is captured at accept so a read sees
    // exactly the writes accepted before it; write responses carry zero,
    // which stands in for the is_read flag along the stages.
    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] w_vin;
    logic [31:0]        r_dat [LATENCY];
    logic [31:0]        w_din [LATENCY];

    always_comb begin
        w_vin    = '0;
        w_vin[0] = w_acc;
        w_din[0] = mem_req.we ? 32'h0 : r_mem[w_idx];
        for (int s = 1; s < LATENCY; s++) begin
            w_vin[s] = r_vld[s-1];
            w_din[s] = r_dat[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_dat[s] <= '0;
            end
        end else begin
            r_vld <= w_vin;
            for (int s = 0; s < LATENCY - 1; s++) begin
                r_dat[s] <= w_din[s];
            end
            // Output data register holds its value between responses.
            if (w_vin[LATENCY-1]) begin
                r_dat[LATENCY-1] <= w_din[LATENCY-1];
            end
        end
    end

    assign mem_rsp.rvalid = r_vld[LATENCY-1];
    assign mem_rsp.rdata  = r_dat[LATENCY-1];
endmodule
